dma_burst_ctrl: RTL and testbench

Parametrised burst DMA controller, the next generation of the lab DMA engine. On a CPU `begin_dma` pulse it requests the memory bus, streams `length` words starting at `target_address` to the external device in bursts of `BURST_LEN`, and optionally releases the bus between bursts (cycle stealing). It tolerates grant withdrawal and memory stalls, and signals completion with a one-cycle `dma_end`. It sits between the CPU bus arbiter (br/bg), main memory and the external device.

---
 rtl/dma_burst_ctrl_if.sv | 27 ++
 rtl/dma_burst_ctrl.sv | 120 ++++++++++++
 tb/tb_dma_burst_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_burst_ctrl_if.sv
// Memory-bus side of the burst DMA controller: arbiter grant,
// memory handshake and the word strobe/address towards the device.
interface dma_burst_ctrl_if #(
    parameter int WORD_SIZE = 16
);
    logic                 br;
    logic                 bg;
    logic                 mem_ready;
    logic                 mtoe;
    logic [WORD_SIZE-1:0] memory_address;

    modport master (
        output br,
        output mtoe,
        output memory_address,
        input  bg,
        input  mem_ready
    );

    modport slave (
        input  br,
        input  mtoe,
        input  memory_address,
        output bg,
        output mem_ready
    );
endinterface

// File: rtl/dma_burst_ctrl.sv
// Burst DMA controller: streams a latched word range from memory to the
// external device in fixed bursts, optionally yielding the bus in between.
module dma_burst_ctrl #(
    parameter int WORD_SIZE   = 16,
    parameter int LEN_W       = 8,
    parameter int BURST_LEN   = 4,
    parameter int CYCLE_STEAL = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 begin_dma,
    input  logic [WORD_SIZE-1:0] length,
    input  logic [WORD_SIZE-1:0] target_address,
    dma_burst_ctrl_if.master     bus,
    output logic [LEN_W-1:0]     index,
    output logic                 busy,
    output logic                 dma_end
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XFER,
        RELEASE,
        DONE
    } state_t;

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] B_LAST = BW'(BURST_LEN - 1);

    state_t               state;
    logic [BW-1:0]        bcnt;
    logic [WORD_SIZE-1:0] base;
    logic [LEN_W-1:0]     len;
    logic                 br_q;
    logic                 mtoe_q;
    logic                 last_word;
    logic                 len_unused;

    // Only the low LEN_W bits of length select the word count.
    assign len_unused = ^length[WORD_SIZE-1:LEN_W];

    assign last_word          = (index == len - 1'b1);
    assign bus.br             = br_q;
    assign bus.mtoe           = mtoe_q;
    assign bus.memory_address = base + WORD_SIZE'(index);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bcnt    <= '0;
            base    <= '0;
            len     <= '0;
            index   <= '0;
            br_q    <= 1'b0;
            mtoe_q  <= 1'b0;
            busy    <= 1'b0;
            dma_end <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (begin_dma) begin
                        base  <= target_address;
                        len   <= length[LEN_W-1:0];
                        index <= '0;
                        bcnt  <= '0;
                        busy  <= 1'b1;
                        if (length[LEN_W-1:0] == '0) begin
                            state   <= DONE;
                            dma_end <= 1'b1;
                        end else begin
                            state <= REQ;
                            br_q  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus.bg) begin
                        state  <= XFER;
                        mtoe_q <= 1'b1;
                    end
                end
                XFER: begin
                    // A withdrawn grant wins over a completing word.
                    if (!bus.bg) begin
                        state  <= REQ;
                        mtoe_q <= 1'b0;
                    end else if (bus.mem_ready) begin
                        bcnt <= (bcnt == B_LAST) ? '0 : bcnt + 1'b1;
                        if (last_word) begin
                            state   <= DONE;
                            br_q    <= 1'b0;
                            mtoe_q  <= 1'b0;
                            dma_end <= 1'b1;
                            index   <= '0;
                        end else begin
                            index <= index + 1'b1;
                            if (bcnt == B_LAST && CYCLE_STEAL != 0) begin
                                state  <= RELEASE;
                                br_q   <= 1'b0;
                                mtoe_q <= 1'b0;
                            end
                        end
                    end
                end
                RELEASE: begin
                    state <= REQ;
                    br_q  <= 1'b1;
                end
                DONE: begin
                    state   <= IDLE;
                    dma_end <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_burst_ctrl.sv
// Directed and randomized bench for dma_burst_ctrl; a monitor logs every
// accepted word and the bench compares against arithmetic expectations.
module tb_dma_burst_ctrl;

    localparam int WS = 16;
    localparam int LW = 8;
    localparam int BL = 4;
    localparam int CS = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          begin_dma = 1'b0;
    logic [WS-1:0] length = '0;
    logic [WS-1:0] target_address = '0;
    logic [LW-1:0] index;
    logic          busy;
    logic          dma_end;

    dma_burst_ctrl_if #(.WORD_SIZE(WS)) bus ();

    dma_burst_ctrl #(
        .WORD_SIZE  (WS),
        .LEN_W      (LW),
        .BURST_LEN  (BL),
        .CYCLE_STEAL(CS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .begin_dma     (begin_dma),
        .length        (length),
        .target_address(target_address),
        .bus           (bus),
        .index         (index),
        .busy          (busy),
        .dma_end       (dma_end)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs = 0;

    int            cyc = 0;
    logic          br_seen = 1'b0;
    logic [15:0]   acc_addr[$];
    int            acc_idx[$];
    int            rel_words[$];
    int            n_end = 0, n_rel = 0, n_br = 0, n_busy = 0, n_nobg = 0;
    int            n_stall_bad = 0, n_idx_bad = 0, n_end_bad = 0;
    int            last_acc_cyc = -10;
    int            drop_at = -100;
    logic          prev_mtoe = 1'b0;
    logic          prev_acc = 1'b0;
    logic [15:0]   prev_addr = '0;

    int s_acc = 0, s_end = 0, s_rel = 0, s_br = 0, s_busy = 0, s_nobg = 0;
    int s_stall = 0, s_idx = 0, s_endbad = 0;
    int cur_len = 0;
    int drop_after = 0;
    int mr_mode = 0;
    bit rand_bg = 1'b0;

    // Monitor: observes the cycle that is ending at each rising edge.
    always @(posedge clk) begin
        logic acc;
        cyc++;
        acc = bus.mtoe && bus.bg && bus.mem_ready;
        if (acc) begin
            acc_addr.push_back(bus.memory_address);
            acc_idx.push_back(int'(index));
            last_acc_cyc = cyc;
            if (drop_after != 0 && acc_addr.size() - s_acc == drop_after)
                drop_at = cyc;
        end
        if (bus.mtoe && prev_mtoe && !prev_acc && bus.memory_address != prev_addr)
            n_stall_bad++;
        if (bus.mtoe && int'(index) >= cur_len) n_idx_bad++;
        if (busy && !bus.br && !dma_end) begin
            n_rel++;
            rel_words.push_back(acc_addr.size() - s_acc);
        end
        if (bus.br) n_br++;
        if (busy) n_busy++;
        if (bus.mtoe && !bus.bg) n_nobg++;
        if (dma_end) begin
            n_end++;
            if (bus.br) n_end_bad++;
            if (acc_addr.size() > s_acc && last_acc_cyc != cyc - 1) n_end_bad++;
        end
        prev_mtoe = bus.mtoe;
        prev_acc  = acc;
        prev_addr = bus.memory_address;
        br_seen   = bus.br;
    end

    // Arbiter and memory models: grant echoes request one cycle later.
    always @(negedge clk) begin
        bit drop;
        drop = (cyc >= drop_at) && (cyc - drop_at < 3);
        bus.bg = br_seen && !drop && !(rand_bg && $urandom_range(0, 4) == 0);
        case (mr_mode)
            0:       bus.mem_ready = 1'b1;
            1:       bus.mem_ready = (cyc % 3 == 0);
            default: bus.mem_ready = ($urandom_range(0, 9) < 7);
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [15:0] l, input logic [15:0] b);
        @(negedge clk);
        s_acc    = acc_addr.size();
        s_end    = n_end;
        s_rel    = n_rel;
        s_br     = n_br;
        s_busy   = n_busy;
        s_nobg   = n_nobg;
        s_stall  = n_stall_bad;
        s_idx    = n_idx_bad;
        s_endbad = n_end_bad;
        cur_len  = int'(l[7:0]);
        length         = l;
        target_address = b;
        begin_dma      = 1'b1;
        @(posedge clk);
        #1;
        chk("start_busy", busy, 1);
        chk("start_br", bus.br, cur_len != 0);
        @(negedge clk);
        begin_dma      = 1'b0;
        length         = 16'($urandom);
        target_address = 16'($urandom);
    endtask

    task automatic wait_end(input int maxc);
        int t;
        t = 0;
        while (n_end == s_end && t < maxc) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("end_seen", n_end != s_end, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_words(input int w, input int maxc);
        int t;
        t = 0;
        while (acc_addr.size() - s_acc < w && t < maxc) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("words_reached", acc_addr.size() - s_acc, w);
    endtask

    task automatic check_xfer(input int l, input logic [15:0] b);
        logic [15:0] ea;
        int          exp_rel;
        exp_rel = (l == 0 || CS == 0) ? 0 : (l - 1) / BL;
        chk("word_count", acc_addr.size() - s_acc, l);
        for (int i = 0; i < l && s_acc + i < acc_addr.size(); i++) begin
            ea = b + 16'(i);
            chk("addr", acc_addr[s_acc + i], ea);
            chk("idx", acc_idx[s_acc + i], i);
        end
        chk("end_pulses", n_end - s_end, 1);
        chk("release_cycles", n_rel - s_rel, exp_rel);
        if (l == 0) begin
            chk("zero_br", n_br - s_br, 0);
            chk("zero_busy", n_busy - s_busy, 1);
        end
        chk("stall_addr", n_stall_bad - s_stall, 0);
        chk("idx_range", n_idx_bad - s_idx, 0);
        chk("end_timing", n_end_bad - s_endbad, 0);
        chk("idle_busy", busy, 0);
        chk("idle_br", bus.br, 0);
        chk("idle_index", index, 0);
        chk("idle_end", dma_end, 0);
    endtask

    initial begin
        logic [15:0] rl;
        logic [15:0] rb;

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_br", bus.br, 0);
        chk("rst_mtoe", bus.mtoe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_end", dma_end, 0);
        chk("rst_index", index, 0);
        chk("rst_addr", bus.memory_address, 0);
        reset = 1'b0;

        start(16'd12, 16'h0020);
        wait_end(300);
        check_xfer(12, 16'h0020);
        chk("gap1_after", rel_words[s_rel], 4);
        chk("gap2_after", rel_words[s_rel + 1], 8);

        start(16'd0, 16'h0040);
        wait_end(20);
        check_xfer(0, 16'h0040);

        drop_after = 2;
        start(16'd6, 16'h0080);
        wait_end(300);
        check_xfer(6, 16'h0080);
        chk("drop_mtoe", n_nobg - s_nobg, 1);
        drop_after = 0;

        mr_mode = 1;
        start(16'd5, 16'h0090);
        wait_end(300);
        check_xfer(5, 16'h0090);
        mr_mode = 0;

        start(16'd8, 16'h0200);
        wait_words(3, 200);
        #2 reset = 1'b1;
        #1;
        chk("async_br", bus.br, 0);
        chk("async_mtoe", bus.mtoe, 0);
        chk("async_busy", busy, 0);
        chk("async_end", dma_end, 0);
        chk("async_index", index, 0);
        chk("async_addr", bus.memory_address, 0);
        chk("async_words", acc_addr.size() - s_acc, 3);
        @(negedge clk);
        reset = 1'b0;
        start(16'd2, 16'h0300);
        wait_end(100);
        check_xfer(2, 16'h0300);

        start(16'd12, 16'h1000);
        wait_words(5, 200);
        @(negedge clk);
        length         = 16'd3;
        target_address = 16'h0500;
        begin_dma      = 1'b1;
        @(negedge clk);
        begin_dma = 1'b0;
        wait_end(300);
        check_xfer(12, 16'h1000);

        mr_mode = 2;
        rand_bg = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rl = 16'($urandom_range(0, 40));
            rb = (k == 0) ? 16'hFFF0 : 16'($urandom);
            start(rl, rb);
            wait_end(2000);
            check_xfer(int'(rl), rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
